// File: rtl/opr1_sequencer.sv
// Group 1 operate microinstruction sequencer: steps a latched OPR1 word through
// clear, complement, increment and rotate/swap events, one registered strobe set per clock.
module opr1_sequencer #(
    parameter bit SKIP_EMPTY = 1'b1
) (
    input  logic        CLK,
    input  logic        RESETn,
    input  logic        START,
    input  logic [11:0] IR,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR,
    output logic        AC_CLR,
    output logic        L_CLR,
    output logic        AC_INV,
    output logic        L_INV,
    output logic        INC,
    output logic        ROT_R,
    output logic        ROT_L,
    output logic        SWAP,
    output logic        LD_AC
);

    typedef enum logic [2:0] {
        S_IDLE, S_E1, S_E2, S_E3, S_E4A, S_E4B, S_FIN
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  ir_q, ir_d;
    logic        err_q, err_d;
    logic [7:0]  strb_q, strb_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        errp_q, errp_d;
    logic        ld_q, ld_d;

    // op bits: 7 CLA, 6 CLL, 5 CMA, 4 CML, 3 RAR, 2 RAL, 1 BSW, 0 IAC
    function automatic logic ev_active(input logic [2:0] k, input logic [7:0] op);
        case (k)
            3'd1:    return op[7] | op[6];
            3'd2:    return op[5] | op[4];
            3'd3:    return op[0];
            3'd4:    return (op[3] ^ op[2]) | (op[1] & ~(op[3] & op[2]));
            default: return 1'b0;
        endcase
    endfunction

    function automatic state_t next_event(input logic [2:0] first, input logic [7:0] op);
        if (first <= 3'd1 && (!SKIP_EMPTY || ev_active(3'd1, op))) return S_E1;
        if (first <= 3'd2 && (!SKIP_EMPTY || ev_active(3'd2, op))) return S_E2;
        if (first <= 3'd3 && (!SKIP_EMPTY || ev_active(3'd3, op))) return S_E3;
        if (first <= 3'd4 && (!SKIP_EMPTY || ev_active(3'd4, op))) return S_E4A;
        return S_FIN;
    endfunction

    // Strobe vector: {AC_CLR, L_CLR, AC_INV, L_INV, INC, ROT_R, ROT_L, SWAP}
    function automatic logic [7:0] strobes(input state_t s, input logic [7:0] op);
        logic [7:0] r;
        r = 8'd0;
        case (s)
            S_E1: begin r[7] = op[7]; r[6] = op[6]; end
            S_E2: begin r[5] = op[5]; r[4] = op[4]; end
            S_E3: r[3] = op[0];
            S_E4A, S_E4B: begin
                if (op[3] ^ op[2]) begin
                    r[2] = op[3];
                    r[1] = op[2];
                end else if (s == S_E4A && op[1] && !op[3] && !op[2]) begin
                    r[0] = 1'b1;
                end
            end
            default: r = 8'd0;
        endcase
        return r;
    endfunction

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (START && IR[11:8] == 4'b1110) begin
                    ir_d    = IR[7:0];
                    err_d   = IR[3] & IR[2];
                    state_d = next_event(3'd1, IR[7:0]);
                end
            end
            S_E1:  state_d = next_event(3'd2, ir_q);
            S_E2:  state_d = next_event(3'd3, ir_q);
            S_E3:  state_d = next_event(3'd4, ir_q);
            // A single rotate combined with BSW is the double rotate: repeat once
            S_E4A: state_d = ((ir_q[3] ^ ir_q[2]) && ir_q[1]) ? S_E4B : S_FIN;
            S_E4B: state_d = S_FIN;
            S_FIN: begin
                state_d = S_IDLE;
                err_d   = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are decoded from the state being entered so they appear registered
        strb_d = strobes(state_d, ir_d);
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_FIN);
        errp_d = (state_d == S_FIN) & err_d;
        ld_d   = |strb_d;
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q <= S_IDLE;
            ir_q    <= 8'd0;
            err_q   <= 1'b0;
            strb_q  <= 8'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            errp_q  <= 1'b0;
            ld_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            err_q   <= err_d;
            strb_q  <= strb_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            errp_q  <= errp_d;
            ld_q    <= ld_d;
        end
    end

    assign BUSY   = busy_q;
    assign DONE   = done_q;
    assign ERR    = errp_q;
    assign AC_CLR = strb_q[7];
    assign L_CLR  = strb_q[6];
    assign AC_INV = strb_q[5];
    assign L_INV  = strb_q[4];
    assign INC    = strb_q[3];
    assign ROT_R  = strb_q[2];
    assign ROT_L  = strb_q[1];
    assign SWAP   = strb_q[0];
    assign LD_AC  = ld_q;

endmodule
